serial_vec_assembler: RTL and testbench
=======================================

// Module: serial_vec_assembler
// PURPOSE
//   Deserialises a gated serial bit stream into WIDTH-bit vectors and presents them on a
//   valid/ready output that feeds vector_splitter.in_vec directly.
//   Single-entry output holding register with a sticky overrun flag.
//   Synchronous flush discards partial words.
// PARAMETERS
//   WIDTH      8  vector width; must be >= 2; default matches the splitter input
//   MSB_FIRST  1  1: first serial bit lands in vec_out[WIDTH-1]; 0: first bit lands in vec_out[0]
// PORTS
//   clk        in   1                     rising-edge clock
//   rst_n      in   1                     asynchronous active-low reset
//   flush      in   1                     synchronous clear of partial word, output and overrun
//   bit_in     in   1                     serial data bit
//   bit_valid  in   1                     bit_in is sampled on this clk edge
//   vec_out    out  WIDTH                 assembled vector (to splitter in_vec)
//   vec_valid  out  1                     vec_out holds an unconsumed vector
//   vec_ready  in   1                     consumer accepts vec_out this cycle
//   bit_cnt    out  $clog2(WIDTH)         bits collected in current partial word
//   overrun    out  1                     sticky: a completed word was dropped
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - shift reg, bit_cnt, vec_out, vec_valid and overrun all go to 0.
//     - Release is synchronous to clk.
//   Shift, on each edge with bit_valid=1:
//     - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], bit_in}
//     - MSB_FIRST=0: sh <= {bit_in, sh[WIDTH-1:1]}
//     - bit_cnt increments; bit_valid=0 holds all state (gaps of any length are legal).
//   Completion: bit_valid=1 with bit_cnt==WIDTH-1.
//     - The word is complete (next-sh value) and bit_cnt wraps to 0.
//   Output FSM, two states: EMPTY (vec_valid=0) and FULL (vec_valid=1).
//     - EMPTY + completion: load vec_out, go to FULL.
//       vec_valid rises on the edge after the last bit is sampled (latency 1).
//     - FULL + vec_ready + completion: load the new word, stay FULL (back-to-back, no bubble).
//     - FULL + vec_ready, no completion: go to EMPTY; vec_out holds its last value.
//     - FULL + !vec_ready + completion: word dropped, vec_out unchanged, overrun <= 1.
//     - FULL + !vec_ready, no completion: hold.
//   vec_out is stable whenever vec_valid=1 and vec_ready=0.
//   flush=1 (highest priority after reset):
//     - Clears sh, bit_cnt, vec_out, vec_valid and overrun.
//     - Any bit_valid in the same cycle is ignored.
//   overrun clears only on reset or flush; it does not block further assembly.
//   No combinational path from inputs to outputs; all outputs are registered.
// STRUCTURE
//   Package vec_pkg:
//     - VEC_W_DEFAULT = 8
//     - typedef enum logic {ST_EMPTY, ST_FULL} out_state_t
//   Sub-module vec_shift_stage (params WIDTH, MSB_FIRST):
//     - Contains the shift reg and bit_cnt.
//     - Outputs word_done and word.
//   The top holds the output FSM, the vec_out register and overrun.
// TESTING
//   1. Byte assembly: MSB_FIRST=1, bits 1,1,0,1,0,1,1,0 on consecutive cycles, vec_ready=1
//      -> vec_out=8'hD6 with vec_valid=1 one cycle after bit 8.
//      -> Downstream splitter shows out1=1101, out2=01, out3=1, out4=0.
//   2. Overrun: vec_ready=0, send 0xA5 then 0x3C
//      -> vec_out stays 8'hA5, overrun=1 after the 16th bit.
//      -> Raise vec_ready: vec_valid drops the next cycle; overrun stays 1 until flush.
//   3. Back-to-back: 0x81 then 0x7E streamed continuously, with vec_ready=1 in the
//      completion cycle of 0x7E
//      -> vec_out goes 81 -> 7E with vec_valid never low; overrun=0.
//   4. Flush mid-word: 5 bits sent, then flush, then 0x0F
//      -> bit_cnt=0 after flush; the next vec_out is 8'h0F (no stale bits).
//   5. Async reset: rst_n pulsed low mid-word and between clk edges while FULL
//      -> all outputs 0 immediately; a clean 0x55 afterwards assembles correctly.
//   6. LSB-first with gaps: MSB_FIRST=0, 0xD6 sent LSB first with random bit_valid gaps
//      -> vec_out=8'hD6.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the serial vector assembler.
// Output-holding states and default vector width.
package vec_pkg;

  localparam int unsigned VEC_W_DEFAULT = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/vec_shift_stage.sv
// Serial-to-parallel shift register with bit counter.
// Flags the cycle in which the last bit of a word is sampled and exposes that word.
module vec_shift_stage #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     word_done,
  output logic [WIDTH-1:0]         word,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] sh_q, sh_d, sh_shift;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_bit;

  if (MSB_FIRST) begin : g_msb
    assign sh_shift = {sh_q[WIDTH-2:0], bit_in};
  end else begin : g_lsb
    assign sh_shift = {bit_in, sh_q[WIDTH-1:1]};
  end

  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));
  // The completed word is the next-state shift value, handed over in the same cycle.
  assign word_done = bit_valid & ~flush & last_bit;
  assign word      = sh_shift;
  assign bit_cnt   = cnt_q;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (flush) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (bit_valid) begin
      sh_d  = sh_shift;
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_vec_assembler.sv
// Deserialises a gated bit stream into WIDTH-bit vectors behind a single-entry
// valid/ready holding register with a sticky overrun flag.
module serial_vec_assembler
  import vec_pkg::*;
#(
  parameter int unsigned WIDTH     = VEC_W_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic [WIDTH-1:0]         vec_out,
  output logic                     vec_valid,
  input  logic                     vec_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);

  logic             word_done;
  logic [WIDTH-1:0] word;

  out_state_t       state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             ovr_q, ovr_d;

  vec_shift_stage #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .word_done (word_done),
    .word      (word),
    .bit_cnt   (bit_cnt)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ovr_d   = ovr_q;
    if (flush) begin
      state_d = ST_EMPTY;
      vec_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (word_done) begin
            vec_d   = word;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (vec_ready) begin
            // Consume and refill in one cycle so a streaming source sees no bubble.
            if (word_done) vec_d = word;
            else           state_d = ST_EMPTY;
          end else if (word_done) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      vec_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ovr_q   <= ovr_d;
    end
  end

  assign vec_out   = vec_q;
  assign vec_valid = (state_q == ST_FULL);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_vec_assembler.sv
// Self-checking bench: MSB-first and LSB-first assemblers share stimulus and are
// compared against a word-level reference model.
module tb_serial_vec_assembler;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, vec_ready = 1'b0;

  logic [W-1:0] vec_out_m, vec_out_l;
  logic         vec_valid_m, vec_valid_l, overrun_m, overrun_l;
  logic [2:0]   bit_cnt_m, bit_cnt_l;

  logic [W-1:0] o_vec [2];
  logic         o_val [2];
  logic         o_ovr [2];
  logic [2:0]   o_cnt [2];
  assign o_vec[0] = vec_out_m;   assign o_vec[1] = vec_out_l;
  assign o_val[0] = vec_valid_m; assign o_val[1] = vec_valid_l;
  assign o_ovr[0] = overrun_m;   assign o_ovr[1] = overrun_l;
  assign o_cnt[0] = bit_cnt_m;   assign o_cnt[1] = bit_cnt_l;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_vec_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
    .vec_out(vec_out_m), .vec_valid(vec_valid_m), .vec_ready(vec_ready),
    .bit_cnt(bit_cnt_m), .overrun(overrun_m)
  );

  serial_vec_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
    .vec_out(vec_out_l), .vec_valid(vec_valid_l), .vec_ready(vec_ready),
    .bit_cnt(bit_cnt_l), .overrun(overrun_l)
  );

  // Reference model: bits are collected in arrival order, a word is formed once W
  // have arrived, and the holding register follows the documented accept/drop rules.
  int           m_bits [2][W];
  int           m_cnt  [2];
  logic [W-1:0] m_vec  [2];
  logic         m_val  [2];
  logic         m_ovr  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_vec[k] = '0; m_val[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic f, input logic bv, input logic b, input logic rdy);
    for (int k = 0; k < 2; k++) begin
      logic         done;
      logic [W-1:0] wd;
      done = 1'b0;
      wd   = '0;
      if (f) begin
        m_cnt[k] = 0; m_vec[k] = '0; m_val[k] = 1'b0; m_ovr[k] = 1'b0;
      end else begin
        if (bv) begin
          m_bits[k][m_cnt[k]] = int'(b);
          m_cnt[k]++;
          if (m_cnt[k] == W) begin
            for (int i = 0; i < W; i++) begin
              // k==0: first bit is the MSB; k==1: first bit is the LSB
              if (m_bits[k][i] != 0) wd[(k == 0) ? (W - 1 - i) : i] = 1'b1;
            end
            done = 1'b1;
            m_cnt[k] = 0;
          end
        end
        if (!m_val[k]) begin
          if (done) begin m_vec[k] = wd; m_val[k] = 1'b1; end
        end else if (rdy) begin
          if (done) m_vec[k] = wd;
          else      m_val[k] = 1'b0;
        end else if (done) begin
          m_ovr[k] = 1'b1;
        end
      end
    end
  endtask

  // One clock: inputs applied before the edge, outputs settled 1 time unit after it.
  task automatic step(input logic f, input logic bv, input logic b, input logic rdy);
    flush = f; bit_valid = bv; bit_in = b; vec_ready = rdy;
    @(posedge clk);
    model_step(f, bv, b, rdy);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit lsb_first, input logic rdy,
                           input bit gaps);
    for (int i = 0; i < W; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) step(1'b0, 1'b0, 1'($urandom), rdy);
      end
      step(1'b0, 1'b1, lsb_first ? w[i] : w[W-1-i], rdy);
    end
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_vec[k] !== '0 || o_val[k] !== 1'b0 || o_ovr[k] !== 1'b0 || o_cnt[k] !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got vec=%h val=%b ovr=%b cnt=%0d want all zero",
                 k, o_vec[k], o_val[k], o_ovr[k], o_cnt[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_byte_assembly();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_word(8'hD6, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (vec_out_m !== 8'hD6 || vec_valid_m !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_assembly: got vec=%h val=%b want vec=d6 val=1", vec_out_m, vec_valid_m);
    end
    n_cmp++;
    if ({vec_out_m[7:4], vec_out_m[3:2], vec_out_m[1], vec_out_m[0]} !== {4'b1101, 2'b01, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL byte_fields: got %b want 11010110", vec_out_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (vec_valid_m !== 1'b0 || vec_out_m !== 8'hD6) begin
      n_fail++;
      $display("FAIL byte_consume: got val=%b vec=%h want val=0 vec=d6", vec_valid_m, vec_out_m);
    end
  endtask

  task automatic test_overrun();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (overrun_m !== 1'b0 || vec_out_m !== 8'hA5) begin
      n_fail++;
      $display("FAIL overrun_first: got ovr=%b vec=%h want ovr=0 vec=a5", overrun_m, vec_out_m);
    end
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (overrun_m !== 1'b1 || vec_out_m !== 8'hA5 || vec_valid_m !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_drop: got ovr=%b vec=%h val=%b want ovr=1 vec=a5 val=1",
               overrun_m, vec_out_m, vec_valid_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (vec_valid_m !== 1'b0 || overrun_m !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got val=%b ovr=%b want val=0 ovr=1", vec_valid_m, overrun_m);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (overrun_m !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_flush: got ovr=%b want 0", overrun_m);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w2;
    bit           dropped;
    w2 = 8'h7E;
    dropped = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h81, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, w2[W-1-i], (i == W - 1) ? 1'b1 : 1'b0);
      if (vec_valid_m !== 1'b1) dropped = 1'b1;
    end
    n_cmp++;
    if (dropped) begin
      n_fail++;
      $display("FAIL b2b_valid: got a low vec_valid want continuously 1");
    end
    n_cmp++;
    if (vec_out_m !== 8'h7E || overrun_m !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_word: got vec=%h ovr=%b want vec=7e ovr=0", vec_out_m, overrun_m);
    end
  endtask

  task automatic test_flush_mid_word();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (bit_cnt_m !== 3'd0 || vec_valid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cnt: got cnt=%0d val=%b want cnt=0 val=0", bit_cnt_m, vec_valid_m);
    end
    send_word(8'h0F, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (vec_out_m !== 8'h0F || vec_valid_m !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_word: got vec=%h val=%b want vec=0f val=1", vec_out_m, vec_valid_m);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (vec_out_m !== '0 || vec_valid_m !== 1'b0 || bit_cnt_m !== '0 || overrun_m !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got vec=%h val=%b cnt=%0d ovr=%b want all zero",
               vec_out_m, vec_valid_m, bit_cnt_m, overrun_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_word(8'h55, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (vec_out_m !== 8'h55 || vec_valid_m !== 1'b1) begin
      n_fail++;
      $display("FAIL async_recover: got vec=%h val=%b want vec=55 val=1", vec_out_m, vec_valid_m);
    end
  endtask

  task automatic test_lsb_gaps();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'hD6, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (vec_out_l !== 8'hD6 || vec_valid_l !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_gaps: got vec=%h val=%b want vec=d6 val=1", vec_out_l, vec_valid_l);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 2) == 0));
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_vec[k] !== m_vec[k] || o_val[k] !== m_val[k] || o_ovr[k] !== m_ovr[k] ||
            o_cnt[k] !== 3'(m_cnt[k])) begin
          n_fail++;
          $display("FAIL random[%0d] cyc %0d: got vec=%h val=%b ovr=%b cnt=%0d want vec=%h val=%b ovr=%b cnt=%0d",
                   k, c, o_vec[k], o_val[k], o_ovr[k], o_cnt[k],
                   m_vec[k], m_val[k], m_ovr[k], m_cnt[k]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_byte_assembly();
    test_overrun();
    test_back_to_back();
    test_flush_mid_word();
    test_async_reset();
    test_lsb_gaps();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
